wb_regfile: RTL

//  Consumer end of the write-back interface: 32x32 register file that accepts

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_scoreboard.sv | 81 ++++++++
 rtl/wb_regfile.sv | 72 +++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared write-back types and control-word bit positions used by WB, decode and the register file.
package wb_pkg;

    localparam int DATA_W            = 32;
    localparam int REG_ADDR_W        = 5;
    localparam int CTRL_MEMTOREG_BIT = 20;
    localparam int CTRL_REGWRITE_BIT = 19;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    // r0 is architecturally zero: never written, never a hazard source.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: per-register in-flight counters, RAW stall and sticky overflow flag.
// Optional macro WB_REGFILE_BYPASS_EN lets a retiring last write satisfy a read without stalling.
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      regWrite,
    input  reg_addr_t writeAddr,
    input  reg_addr_t rsAddr,
    input  reg_addr_t rtAddr,
    input  logic      rsUsed,
    input  logic      rtUsed,
    input  logic      issueValid,
    input  logic      issueRegWrite,
    input  reg_addr_t issueDest,
    output logic      stall,
    output logic      sbOverflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;
    logic             ovf_hit;
    logic             rs_bypass_ok;
    logic             rt_bypass_ok;
    logic             rs_busy;
    logic             rt_busy;

    // One-hot issue/retire decode; an issue and retire on the same register cancel out.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issueValid && issueRegWrite && !is_zero_reg(issueDest)) begin
            inc_vec[issueDest] = 1'b1;
        end
        if (regWrite && !is_zero_reg(writeAddr)) begin
            dec_vec[writeAddr] = 1'b1;
        end
        ovf_hit = ((inc_vec & ~dec_vec) != '0) && (cnt[issueDest] == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= '0;
            end
            sbOverflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (inc_vec[i] && !dec_vec[i] && cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            if (ovf_hit) begin
                sbOverflow <= 1'b1;
            end
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign rs_bypass_ok = regWrite && (writeAddr == rsAddr) && (cnt[rsAddr] == CNT_ONE);
    assign rt_bypass_ok = regWrite && (writeAddr == rtAddr) && (cnt[rtAddr] == CNT_ONE);
`else
    assign rs_bypass_ok = 1'b0;
    assign rt_bypass_ok = 1'b0;
`endif

    assign rs_busy = rsUsed && !is_zero_reg(rsAddr) && (cnt[rsAddr] != '0) && !rs_bypass_ok;
    assign rt_busy = rtUsed && !is_zero_reg(rtAddr) && (cnt[rtAddr] != '0) && !rt_bypass_ok;
    assign stall   = rs_busy || rt_busy;

endmodule

// File: rtl/wb_regfile.sv
// Register file at the consumer end of write-back, with two combinational decode read ports.
// Optional macro WB_REGFILE_BYPASS_EN forwards same-cycle write-back data to the read ports.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  data_t     writeBackData,
    input  logic      regWrite,
    input  reg_addr_t writeAddr,
    input  reg_addr_t rsAddr,
    input  reg_addr_t rtAddr,
    input  logic      rsUsed,
    input  logic      rtUsed,
    input  logic      issueValid,
    input  logic      issueRegWrite,
    input  reg_addr_t issueDest,
    output data_t     rsData,
    output data_t     rtData,
    output logic      stall,
    output logic      sbOverflow
);

    data_t regs [NREGS];

    // Reset wins over a same-cycle write-back, so an in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite && !is_zero_reg(writeAddr)) begin
            regs[writeAddr] <= writeBackData;
        end
    end

    always_comb begin
        rsData = is_zero_reg(rsAddr) ? '0 : regs[rsAddr];
        rtData = is_zero_reg(rtAddr) ? '0 : regs[rtAddr];
`ifdef WB_REGFILE_BYPASS_EN
        if (regWrite && !is_zero_reg(rsAddr) && writeAddr == rsAddr) begin
            rsData = writeBackData;
        end
        if (regWrite && !is_zero_reg(rtAddr) && writeAddr == rtAddr) begin
            rtData = writeBackData;
        end
`endif
    end

    wb_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .regWrite      (regWrite),
        .writeAddr     (writeAddr),
        .rsAddr        (rsAddr),
        .rtAddr        (rtAddr),
        .rsUsed        (rsUsed),
        .rtUsed        (rtUsed),
        .issueValid    (issueValid),
        .issueRegWrite (issueRegWrite),
        .issueDest     (issueDest),
        .stall         (stall),
        .sbOverflow    (sbOverflow)
    );

endmodule
